decode_ctrl_stage: RTL and testbench
====================================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter OP_W, 6, opcode width.
REQ-002 Parameter ALUOP_W, 3, ALU-op code width; SHALL be >= 3.
REQ-003 Parameter REG_W, 5, register-specifier width.
REQ-004 Parameter CNT_W, 16, stall-counter width.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 valid_i  in  1  IF/ID holds a live instruction.
REQ-008 instr_op_i  in  OP_W  opcode of the ID-stage instruction.
REQ-009 rs_i / rt_i  in  REG_W each  source specifiers of the ID-stage instruction.
REQ-010 flush_i  in  1  squash the ID-stage instruction (taken branch).
REQ-011 stall_o  out  1  combinational hold for PC and IF/ID.
REQ-012 ex_valid_o, ex_RegWrite_o, ex_ALUSrc_o, ex_RegDst_o, ex_Branch_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o  out  1 each  registered ID/EX control.
REQ-013 ex_ALU_op_o  out  ALUOP_W  registered ALU-op code.
REQ-014 ex_rt_o  out  REG_W  registered rt of the EX-stage instruction.
REQ-015 illegal_o  out  1  sticky flag: an unknown opcode was accepted.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-017 Decode (opcode -> ALU_op, RegWrite, ALUSrc, RegDst, Branch, MemRead, MemWrite, MemtoReg): 0 R -> 1,1,0,1,0,0,0,1; 8 addi -> 2,1,1,0,0,0,0,1; 10 slti -> 3,1,1,0,0,0,0,1; 4 beq -> 4,0,0,0,1,0,0,1; 35 lw -> 5,1,1,0,0,1,0,0; 43 sw -> 6,0,1,0,0,0,1,1.
REQ-018 MemtoReg=0 SHALL select memory data; 1 selects ALU result.
REQ-019 Bubble SHALL be: all ex_* control bits 0, ex_ALU_op_o 0, ex_valid_o 0, ex_rt_o 0.
REQ-020 Load-use hazard = valid_i & ex_valid_o & ex_MemRead_o & (ex_rt_o!=0) & (ex_rt_o==rs_i | (ex_rt_o==rt_i & opcode in {R, beq, sw})).
REQ-021 stall_o SHALL equal hazard & ~flush_i.
REQ-022 Each edge, priority: rst_i > flush_i (bubble) > stall_o (bubble) > ~valid_i (bubble) > load decoded instruction with ex_valid_o=1, ex_rt_o=rt_i.
REQ-023 Latency: decoded controls appear on ex_* exactly one cycle after acceptance.
REQ-024 A single lw SHALL cause at most one stall cycle, since the inserted bubble clears ex_MemRead_o.
REQ-025 Unknown opcode with valid_i and neither flush nor stall: bubble loaded, illegal_o set to 1 and held until reset.
REQ-026 stall_cnt_o SHALL increment on every cycle with stall_o=1 and saturate at all-ones.

Reset
REQ-027 On an edge with rst_i=1: all ex_* outputs 0, illegal_o 0, stall_cnt_o 0; stall_o is 0 from the following cycle on.
REQ-028 Reset asserted mid-stall SHALL discard the stall; no counter increment on that edge.

Configuration
REQ-029 With JUMP_EN defined: additional outputs ex_Jump_o and ex_Link_o (1 each); opcode 2 (j) decodes with Jump=1 and all other bits 0; opcode 3 (jal) decodes with Jump=1, Link=1, RegWrite=1, MemtoReg=1, and all other bits 0; both set ex_valid_o.
REQ-030 Without JUMP_EN: ex_Jump_o and ex_Link_o are absent; opcodes 2 and 3 are illegal per REQ-025.

Verification
REQ-031 Reset, then addi (op 8) with valid_i=1 -> next cycle ex_ALU_op_o=2, RegWrite=1, ALUSrc=1, MemtoReg=1, ex_valid_o=1.
REQ-032 lw rt=5, then add rs=5 -> stall_o=1 for one cycle, bubble in EX, add issues on the following cycle, stall_cnt_o=1.
REQ-033 lw rt=0, then add rs=0 -> stall_o stays 0.
REQ-034 Hazard condition with flush_i=1 -> stall_o=0, bubble loaded, stall_cnt_o unchanged.
REQ-035 Opcode 63 with valid_i=1 -> bubble loaded, illegal_o=1 and still 1 after ten further sw instructions; rst_i clears it.
REQ-036 Force CNT_W=2 and trigger 5 load-use stalls -> stall_cnt_o=3.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: ID-stage control decode, load-use hazard detection and
// the ID/EX control pipeline register.
// Optional feature: define JUMP_EN to add j/jal decode with the ex_Jump_o and
// ex_Link_o outputs. Without it, opcodes 2 and 3 are treated as unknown.
module decode_ctrl_stage #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [REG_W-1:0]   rt_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic               ex_RegWrite_o,
  output logic               ex_ALUSrc_o,
  output logic               ex_RegDst_o,
  output logic               ex_Branch_o,
  output logic               ex_MemRead_o,
  output logic               ex_MemWrite_o,
  output logic               ex_MemtoReg_o,
  output logic [ALUOP_W-1:0] ex_ALU_op_o,
  output logic [REG_W-1:0]   ex_rt_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   stall_cnt_o
`ifdef JUMP_EN
  ,
  output logic               ex_Jump_o,
  output logic               ex_Link_o
`endif
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);

  // Decoded control bundle; the all-zero value is the bubble.
  typedef struct packed {
    logic               jump;
    logic               link;
    logic               reg_write;
    logic               alu_src;
    logic               reg_dst;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  ctrl_t              dec_ctrl;
  logic               dec_known;
  logic               dec_uses_rt;
  logic               hazard;

  ctrl_t              ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic [REG_W-1:0]   rt_q, rt_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Opcode decode of the ID-stage instruction (MemtoReg=0 selects memory data).
  always_comb begin
    dec_ctrl    = '0;
    dec_known   = 1'b1;
    dec_uses_rt = 1'b0;
    case (instr_op_i)
      OP_R: begin
        dec_ctrl.alu_op = ALUOP_W'(1); dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst = 1'b1; dec_ctrl.mem_to_reg = 1'b1;
        dec_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.alu_op = ALUOP_W'(2); dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src = 1'b1; dec_ctrl.mem_to_reg = 1'b1;
      end
      OP_SLTI: begin
        dec_ctrl.alu_op = ALUOP_W'(3); dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src = 1'b1; dec_ctrl.mem_to_reg = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.alu_op = ALUOP_W'(4); dec_ctrl.branch = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_uses_rt = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.alu_op = ALUOP_W'(5); dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src = 1'b1; dec_ctrl.mem_read = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_op = ALUOP_W'(6); dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mem_write = 1'b1; dec_ctrl.mem_to_reg = 1'b1;
        dec_uses_rt = 1'b1;
      end
`ifdef JUMP_EN
      OP_J: begin
        dec_ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl.jump = 1'b1; dec_ctrl.link = 1'b1;
        dec_ctrl.reg_write = 1'b1; dec_ctrl.mem_to_reg = 1'b1;
      end
`endif
      default: dec_known = 1'b0;
    endcase
  end

  // Load-use hazard against the load currently in EX; r0 never conflicts.
  always_comb begin
    hazard = valid_i & valid_q & ctrl_q.mem_read & (rt_q != '0) &
             ((rt_q == rs_i) | ((rt_q == rt_i) & dec_uses_rt));
    stall_o = hazard & ~flush_i;
  end

  // Next ID/EX contents: flush > stall > idle > unknown opcode > load.
  always_comb begin
    ctrl_d    = '0;
    valid_d   = 1'b0;
    rt_d      = '0;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (stall_o && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    if (!flush_i && !stall_o && valid_i) begin
      if (dec_known) begin
        ctrl_d  = dec_ctrl;
        valid_d = 1'b1;
        rt_d    = rt_i;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  // Pipeline register, sticky illegal flag and stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rt_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      rt_q      <= rt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_RegWrite_o = ctrl_q.reg_write;
  assign ex_ALUSrc_o   = ctrl_q.alu_src;
  assign ex_RegDst_o   = ctrl_q.reg_dst;
  assign ex_Branch_o   = ctrl_q.branch;
  assign ex_MemRead_o  = ctrl_q.mem_read;
  assign ex_MemWrite_o = ctrl_q.mem_write;
  assign ex_MemtoReg_o = ctrl_q.mem_to_reg;
  assign ex_ALU_op_o   = ctrl_q.alu_op;
  assign ex_rt_o       = rt_q;
  assign illegal_o     = illegal_q;
  assign stall_cnt_o   = cnt_q;
`ifdef JUMP_EN
  assign ex_Jump_o     = ctrl_q.jump;
  assign ex_Link_o     = ctrl_q.link;
`else
  // Jump/link bits only exist to keep the bundle uniform; unused here.
  logic unused_jump;
  assign unused_jump = ctrl_q.jump | ctrl_q.link;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: one default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation check.
module tb_decode_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst, valid, flush;
  logic [5:0] op;
  logic [4:0] rs, rt;

  logic       stall, exv, rw, asrc, rdst, br, mrd, mwr, m2r, ill;
  logic [2:0] aluop;
  logic [4:0] exrt;
  logic [15:0] cnt;

  logic       stall2, exv2, rw2, asrc2, rdst2, br2, mrd2, mwr2, m2r2, ill2;
  logic [2:0] aluop2;
  logic [4:0] exrt2;
  logic [1:0] cnt2;
`ifdef JUMP_EN
  logic jmp, lnk, jmp2, lnk2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .instr_op_i(op),
    .rs_i(rs), .rt_i(rt), .flush_i(flush), .stall_o(stall),
    .ex_valid_o(exv), .ex_RegWrite_o(rw), .ex_ALUSrc_o(asrc),
    .ex_RegDst_o(rdst), .ex_Branch_o(br), .ex_MemRead_o(mrd),
    .ex_MemWrite_o(mwr), .ex_MemtoReg_o(m2r), .ex_ALU_op_o(aluop),
    .ex_rt_o(exrt), .illegal_o(ill), .stall_cnt_o(cnt)
`ifdef JUMP_EN
    , .ex_Jump_o(jmp), .ex_Link_o(lnk)
`endif
  );

  decode_ctrl_stage #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .instr_op_i(op),
    .rs_i(rs), .rt_i(rt), .flush_i(flush), .stall_o(stall2),
    .ex_valid_o(exv2), .ex_RegWrite_o(rw2), .ex_ALUSrc_o(asrc2),
    .ex_RegDst_o(rdst2), .ex_Branch_o(br2), .ex_MemRead_o(mrd2),
    .ex_MemWrite_o(mwr2), .ex_MemtoReg_o(m2r2), .ex_ALU_op_o(aluop2),
    .ex_rt_o(exrt2), .illegal_o(ill2), .stall_cnt_o(cnt2)
`ifdef JUMP_EN
    , .ex_Jump_o(jmp2), .ex_Link_o(lnk2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] s,
                       input logic [4:0] t, input logic f);
    valid = v; op = o; rs = s; rt = t; flush = f;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_exv", exv, 0);
    chk("rst_aluop", aluop, 0);
    chk("rst_rt", exrt, 0);
    chk("rst_ill", ill, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;

    // addi
    drive(1'b1, 6'd8, 5'd1, 5'd2, 1'b0);
    #1 chk("addi_nostall", stall, 0);
    tick();
    chk("addi_aluop", aluop, 2);
    chk("addi_ctrl", {exv, rw, asrc, rdst, br, mrd, mwr, m2r}, 8'b11100001);
    chk("addi_rt", exrt, 2);

    // lw rt=5 then add rs=5: one stall cycle, then add issues
    drive(1'b1, 6'd35, 5'd0, 5'd5, 1'b0);
    tick();
    chk("lw_aluop", aluop, 5);
    chk("lw_ctrl", {exv, rw, asrc, rdst, br, mrd, mwr, m2r}, 8'b11100100);
    chk("lw_rt", exrt, 5);
    drive(1'b1, 6'd0, 5'd5, 5'd3, 1'b0);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_v", exv, 0);
    chk("lu_bubble_op", aluop, 0);
    chk("lu_bubble_rt", exrt, 0);
    chk("lu_cnt", cnt, 1);
    chk("lu_stall_clr", stall, 0);
    tick();
    chk("add_aluop", aluop, 1);
    chk("add_ctrl", {exv, rw, asrc, rdst, br, mrd, mwr, m2r}, 8'b11010001);
    chk("add_rt", exrt, 3);
    chk("add_cnt", cnt, 1);

    // lw rt=0 then add rs=0: r0 never stalls
    drive(1'b1, 6'd35, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd0, 5'd0, 1'b0);
    #1 chk("r0_nostall", stall, 0);
    tick();
    chk("r0_issue", exv, 1);

    // rt match: addi ignores rt, sw uses it
    drive(1'b1, 6'd35, 5'd0, 5'd7, 1'b0);
    tick();
    drive(1'b1, 6'd8, 5'd1, 5'd7, 1'b0);
    #1 chk("addi_rt_nostall", stall, 0);
    tick();
    drive(1'b1, 6'd35, 5'd0, 5'd7, 1'b0);
    tick();
    drive(1'b1, 6'd43, 5'd1, 5'd7, 1'b0);
    #1 chk("sw_rt_stall", stall, 1);
    tick();
    chk("sw_cnt", cnt, 2);
    chk("sw_bubble", exv, 0);
    tick();
    chk("sw_aluop", aluop, 6);
    chk("sw_ctrl", {exv, rw, asrc, rdst, br, mrd, mwr, m2r}, 8'b10100011);

    // beq uses rt too; slti decode
    drive(1'b1, 6'd10, 5'd2, 5'd9, 1'b0);
    tick();
    chk("slti_aluop", aluop, 3);
    chk("slti_ctrl", {exv, rw, asrc, rdst, br, mrd, mwr, m2r}, 8'b11100001);
    drive(1'b1, 6'd4, 5'd2, 5'd9, 1'b0);
    tick();
    chk("beq_aluop", aluop, 4);
    chk("beq_ctrl", {exv, rw, asrc, rdst, br, mrd, mwr, m2r}, 8'b10001001);

    // hazard masked by flush
    drive(1'b1, 6'd35, 5'd0, 5'd4, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd4, 5'd1, 1'b1);
    #1 chk("flush_nostall", stall, 0);
    tick();
    chk("flush_bubble", exv, 0);
    chk("flush_cnt", cnt, 2);

    // idle cycle
    drive(1'b0, 6'd8, 5'd1, 5'd2, 1'b0);
    tick();
    chk("idle_bubble", exv, 0);
    chk("idle_ill", ill, 0);

    // unknown opcode, sticky illegal
    drive(1'b1, 6'd63, 5'd1, 5'd2, 1'b0);
    tick();
    chk("op63_bubble", exv, 0);
    chk("op63_ill", ill, 1);
    drive(1'b1, 6'd43, 5'd1, 5'd2, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("ill_sticky", ill, 1);
    chk("ill_sw_issue", exv, 1);
    rst = 1'b1;
    tick();
    chk("ill_rst", ill, 0);
    chk("ill_rst_cnt", cnt, 0);
    rst = 1'b0;

    // opcode 2 (j)
    drive(1'b1, 6'd2, 5'd0, 5'd0, 1'b0);
    tick();
`ifdef JUMP_EN
    chk("j_issue", {exv, jmp, lnk, rw}, 4'b1100);
    chk("j_ill", ill, 0);
`else
    chk("j_bubble", exv, 0);
    chk("j_ill", ill, 1);
`endif

    // reset in the middle of a stall discards it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 6'd35, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd5, 5'd0, 1'b0);
    #1 chk("mid_stall", stall, 1);
    rst = 1'b1;
    tick();
    chk("mid_cnt", cnt, 0);
    chk("mid_exv", exv, 0);
    chk("mid_stall_clr", stall, 0);
    rst = 1'b0;

    // five load-use stalls: 16-bit counter reads 5, 2-bit saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'd35, 5'd0, 5'd6, 1'b0);
      tick();
      drive(1'b1, 6'd0, 5'd6, 5'd0, 1'b0);
      tick();
      tick();
    end
    chk("sat_cnt16", cnt, 5);
    chk("sat_cnt2", cnt2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
